// File: rtl/mat_mult_pkg.sv
// -----------------------------------------------------------------------------
// mat_mult_pkg
// Shared definitions for the 3x3 matrix multiplier.
//   N         : matrix dimension (rows = columns = 3)
//   elem_lsb  : bit offset of element (i,j) inside a row-major packed bus in
//               which element (0,0) sits at the MSBs
// -----------------------------------------------------------------------------
package mat_mult_pkg;

    localparam int N = 3;

    // Element (i,j) is the (3i+j)-th element counted from the MSB end, so its
    // LSB sits (8-(3i+j)) element widths above bit 0.
    function automatic int elem_lsb(input int i, input int j, input int dw);
        return (8 - (3 * i + j)) * dw;
    endfunction

endpackage

// File: rtl/mat_mult_dot3.sv
// -----------------------------------------------------------------------------
// mat_mult_dot3
// Purely combinational 3-term unsigned dot product at full precision.
// Ports:
//   a0_i..a2_i : left-hand terms, DW bits each
//   b0_i..b2_i : right-hand terms, DW bits each
//   sum_o      : a0*b0 + a1*b1 + a2*b2, 2*DW+2 bits so it can never wrap
// -----------------------------------------------------------------------------
module mat_mult_dot3 #(
    parameter int DW = 8
) (
    input  logic [DW-1:0]     a0_i,
    input  logic [DW-1:0]     a1_i,
    input  logic [DW-1:0]     a2_i,
    input  logic [DW-1:0]     b0_i,
    input  logic [DW-1:0]     b1_i,
    input  logic [DW-1:0]     b2_i,
    output logic [2*DW+1:0]   sum_o
);

    localparam int SW = 2 * DW + 2;

    // Operands are widened before multiplying so that neither the products
    // nor their sum are evaluated at the narrower input width.
    always_comb begin
        sum_o = SW'(a0_i) * SW'(b0_i)
              + SW'(a1_i) * SW'(b1_i)
              + SW'(a2_i) * SW'(b2_i);
    end

endmodule

// File: rtl/mat_mult.sv
// -----------------------------------------------------------------------------
// mat_mult
// Synchronous 3x3 unsigned matrix multiplier, Res = A x B, one-cycle latency.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, wins over in_valid
//   in_valid  : A and B carry a pair to multiply this cycle
//   A, B      : 9 x DW row-major packed matrices, element (0,0) at the MSBs
//   Res       : registered product, each element taken modulo 2^DW
//   out_valid : Res/ovf were loaded on the last edge
//   ovf       : per-element overflow, bit 8-(3i+j) belongs to element (i,j)
// -----------------------------------------------------------------------------
module mat_mult
    import mat_mult_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [9*DW-1:0] A,
    input  logic [9*DW-1:0] B,
    output logic [9*DW-1:0] Res,
    output logic            out_valid,
    output logic [8:0]      ovf
);

    logic [9*DW-1:0] res_d;
    logic [9*DW-1:0] res_q;
    logic [8:0]      ovf_d;
    logic [8:0]      ovf_q;
    logic            valid_q;

    // One dot-product leaf per result element: row i of A against column j
    // of B. The full-precision sum is split into the stored low DW bits and
    // an overflow flag that is set whenever any upper bit is non-zero.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam int LSB = elem_lsb(i, j, DW);
            localparam int IDX = 8 - (3 * i + j);

            logic [2*DW+1:0] sum;

            mat_mult_dot3 #(
                .DW (DW)
            ) u_dot (
                .a0_i  (A[elem_lsb(i, 0, DW) +: DW]),
                .a1_i  (A[elem_lsb(i, 1, DW) +: DW]),
                .a2_i  (A[elem_lsb(i, 2, DW) +: DW]),
                .b0_i  (B[elem_lsb(0, j, DW) +: DW]),
                .b1_i  (B[elem_lsb(1, j, DW) +: DW]),
                .b2_i  (B[elem_lsb(2, j, DW) +: DW]),
                .sum_o (sum)
            );

            assign res_d[LSB +: DW] = sum[DW-1:0];
            assign ovf_d[IDX]       = |sum[2*DW+1:DW];
        end
    end

    // Output registers. Result and flags only load on a valid pair, so
    // garbage or X on A/B during idle cycles never reaches the outputs.
    // The valid strobe simply follows in_valid one cycle later, giving full
    // back-to-back throughput with no stall path.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign Res       = res_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mat_mult.sv
// -----------------------------------------------------------------------------
// tb_mat_mult
// Directed testbench for mat_mult with hand-computed expected matrices.
// -----------------------------------------------------------------------------
module tb_mat_mult;

    localparam int DW = 8;

    // Hand-packed operand and result matrices, element (0,0) first (MSBs).
    localparam logic [71:0] NOM_A   = {8'd3, 8'd1, 8'd1,  8'd2, 8'd1, 8'd9,  8'd9, 8'd5, 8'd9};
    localparam logic [71:0] NOM_B   = {8'd10, 8'd3, 8'd1, 8'd1, 8'd4, 8'd1,  8'd9, 8'd9, 8'd5};
    localparam logic [71:0] NOM_R   = {8'd40, 8'd22, 8'd9, 8'd102, 8'd91, 8'd48, 8'd176, 8'd128, 8'd59};
    localparam logic [71:0] ID_A    = {8'd1, 8'd0, 8'd0,  8'd0, 8'd1, 8'd0,  8'd0, 8'd0, 8'd1};
    localparam logic [71:0] SEQ_B   = {8'd1, 8'd2, 8'd3,  8'd4, 8'd5, 8'd6,  8'd7, 8'd8, 8'd9};
    localparam logic [71:0] ALL_FF  = {9{8'd255}};
    localparam logic [71:0] ALL_3   = {9{8'd3}};
    localparam logic [71:0] ZERO    = '0;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [9*DW-1:0] A;
    logic [9*DW-1:0] B;
    logic [9*DW-1:0] Res;
    logic            out_valid;
    logic [8:0]      ovf;

    int assertCount = 0;
    int failCount   = 0;

    mat_mult #(
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Res       (Res),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    // Free-running 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs on the falling edge, then let the rising edge
    // capture them and move to 1 time unit past it for sampling.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [71:0] a, input logic [71:0] b);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against its expected value.
    task automatic checkOutput(input string tag, input logic [71:0] expRes,
                               input logic [8:0] expOvf, input logic expValid);
        assertCount++;
        assert (Res === expRes) else begin
            failCount++;
            $error("[TB] FAIL %s.Res: observed %h expected %h", tag, Res, expRes);
        end
        assertCount++;
        assert (ovf === expOvf) else begin
            failCount++;
            $error("[TB] FAIL %s.ovf: observed %h expected %h", tag, ovf, expOvf);
        end
        assertCount++;
        assert (out_valid === expValid) else begin
            failCount++;
            $error("[TB] FAIL %s.out_valid: observed %b expected %b", tag, out_valid, expValid);
        end
    endtask

    // Linear directed sequence covering every required scenario.
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;

        applyStimulus(1'b1, 1'b0, ZERO, ZERO);
        applyStimulus(1'b1, 1'b0, ZERO, ZERO);
        checkOutput("reset", ZERO, 9'h000, 1'b0);

        applyStimulus(1'b0, 1'b1, NOM_A, NOM_B);
        checkOutput("nominal", NOM_R, 9'h000, 1'b1);

        // Idle with X operands: result must hold, valid must drop.
        applyStimulus(1'b0, 1'b0, 'x, 'x);
        checkOutput("nominal_hold", NOM_R, 9'h000, 1'b0);

        applyStimulus(1'b0, 1'b1, ID_A, SEQ_B);
        checkOutput("identity", SEQ_B, 9'h000, 1'b1);

        applyStimulus(1'b0, 1'b1, ALL_FF, ALL_FF);
        checkOutput("overflow", ALL_3, 9'h1FF, 1'b1);

        applyStimulus(1'b0, 1'b1, ZERO, NOM_B);
        checkOutput("zero", ZERO, 9'h000, 1'b1);

        applyStimulus(1'b0, 1'b0, ZERO, ZERO);
        checkOutput("zero_hold", ZERO, 9'h000, 1'b0);

        // Three consecutive valid pairs.
        applyStimulus(1'b0, 1'b1, NOM_A, NOM_B);
        checkOutput("b2b_0", NOM_R, 9'h000, 1'b1);
        applyStimulus(1'b0, 1'b1, ID_A, SEQ_B);
        checkOutput("b2b_1", SEQ_B, 9'h000, 1'b1);
        applyStimulus(1'b0, 1'b1, ALL_FF, ALL_FF);
        checkOutput("b2b_2", ALL_3, 9'h1FF, 1'b1);
        applyStimulus(1'b0, 1'b0, ZERO, ZERO);
        checkOutput("b2b_end", ALL_3, 9'h1FF, 1'b0);

        // Reset together with a valid pair while a result is present.
        applyStimulus(1'b0, 1'b1, NOM_A, NOM_B);
        checkOutput("pre_reset", NOM_R, 9'h000, 1'b1);
        applyStimulus(1'b1, 1'b1, ALL_FF, ALL_FF);
        checkOutput("reset_wins", ZERO, 9'h000, 1'b0);
        applyStimulus(1'b0, 1'b1, ID_A, SEQ_B);
        checkOutput("post_reset", SEQ_B, 9'h000, 1'b1);
        applyStimulus(1'b0, 1'b0, ZERO, ZERO);
        checkOutput("post_reset_hold", SEQ_B, 9'h000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
